// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises rx_in, oversamples 16x per bit, filters start glitches, majority-votes each bit.
// Optional macro UART_RX_PARITY_EN: receive a ninth (parity) bit after the 8 data bits.
// All outputs are registered; vote results appear the cycle after the os_cnt==9 tick.
module uart_rx_sampler #(
  parameter int DIV = 4,
  parameter int OVS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_in,
  output logic       rx_start,
  output logic       start_check,
  output logic       rx_data_signal,
  output logic       rx_bit,
  output logic [3:0] bit_index,
  output logic       stop_check,
  output logic       frame_err,
  output logic       busy
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]      OS_LAST  = 4'(OVS - 1);
  localparam logic [3:0]      OS_S7    = 4'd7;
  localparam logic [3:0]      OS_S8    = 4'd8;
  localparam logic [3:0]      OS_VOTE  = 4'd9;
`ifdef UART_RX_PARITY_EN
  localparam logic [3:0]      LAST_IDX = 4'd8;
`else
  localparam logic [3:0]      LAST_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1, sync2;
  logic          rxs;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    os_q, os_d;
  logic          samp7_q, samp7_d, samp8_q, samp8_d;
  logic          counting, tick, vote_tick, end_tick, vote;
  logic          rx_start_d, start_check_d, data_sig_d, rx_bit_d;
  logic [3:0]    bit_index_d;
  logic          stop_check_d, frame_err_d;

  assign rxs       = sync2;
  assign counting  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  assign tick      = (div_q == DIV_LAST);
  assign vote_tick = counting && tick && (os_q == OS_VOTE);
  assign end_tick  = counting && tick && (os_q == OS_LAST);
  // Third sample is the live synchronised line on the vote tick itself.
  assign vote      = (samp7_q & samp8_q) | (samp7_q & rxs) | (samp8_q & rxs);
  assign busy      = (state_q != ST_IDLE);

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  // State, counters, samples and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      os_q           <= '0;
      samp7_q        <= 1'b0;
      samp8_q        <= 1'b0;
      rx_start       <= 1'b0;
      start_check    <= 1'b0;
      rx_data_signal <= 1'b0;
      rx_bit         <= 1'b0;
      bit_index      <= '0;
      stop_check     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      os_q           <= os_d;
      samp7_q        <= samp7_d;
      samp8_q        <= samp8_d;
      rx_start       <= rx_start_d;
      start_check    <= start_check_d;
      rx_data_signal <= data_sig_d;
      rx_bit         <= rx_bit_d;
      bit_index      <= bit_index_d;
      stop_check     <= stop_check_d;
      frame_err      <= frame_err_d;
    end
  end

  // Next-state, tick generation, sample capture and pulse decode.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    os_d          = os_q;
    samp7_d       = samp7_q;
    samp8_d       = samp8_q;
    rx_start_d    = 1'b0;
    data_sig_d    = 1'b0;
    stop_check_d  = 1'b0;
    frame_err_d   = 1'b0;
    start_check_d = start_check;
    rx_bit_d      = rx_bit;
    bit_index_d   = bit_index;

    if (!enable) begin
      // Abort: counters cleared, last voted bit and index kept for inspection.
      state_d       = ST_IDLE;
      div_d         = '0;
      os_d          = '0;
      start_check_d = 1'b0;
    end else begin
      if (counting) begin
        if (tick) begin
          div_d = '0;
          os_d  = (os_q == OS_LAST) ? 4'd0 : os_q + 4'd1;
          if (os_q == OS_S7) samp7_d = rxs;
          if (os_q == OS_S8) samp8_d = rxs;
        end else begin
          div_d = div_q + DW'(1);
        end
      end else begin
        // Counters sit at zero outside a frame so START always begins aligned to the edge.
        div_d = '0;
        os_d  = '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!rxs) state_d = ST_START;
        end
        ST_START: begin
          if (vote_tick) begin
            if (vote) begin
              state_d = ST_IDLE;
            end else begin
              rx_start_d    = 1'b1;
              start_check_d = 1'b1;
            end
          end else if (end_tick) begin
            state_d     = ST_DATA;
            bit_index_d = 4'd0;
          end
        end
        ST_DATA: begin
          if (vote_tick) begin
            data_sig_d = 1'b1;
            rx_bit_d   = vote;
          end else if (end_tick) begin
            if (bit_index == LAST_IDX) state_d = ST_STOP;
            else                       bit_index_d = bit_index + 4'd1;
          end
        end
        ST_STOP: begin
          if (vote_tick) begin
            start_check_d = 1'b0;
            if (vote) begin
              stop_check_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // A held-low line must return high before another start is accepted.
          if (rxs) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Front end of the UART receiver, directly upstream of the receive control path. Synchronises the asynchronous serial line, oversamples it 16x, validates the start bit with glitch rejection and majority-votes each bit at mid-bit. Emits one-cycle bit strobes (`rx_data_signal`) with the voted value, plus `rx_start`, `start_check` and `stop_check` flags that the control path and data path consume.

## Interface
- `DIV`, 4: system clocks per oversample tick (baud = f_clock / (16·DIV)); legal range ≥ 2.
- `OVS`, 16: oversample ticks per bit; fixed, not to be overridden.

- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  receiver enable; low aborts any frame and holds IDLE.
- `rx_in`  in  1  raw serial line, asynchronous; idle high.
- `rx_start`  out  1  one-cycle pulse when a start bit is confirmed.
- `start_check`  out  1  high from start confirmation until the frame ends or aborts.
- `rx_data_signal`  out  1  one-cycle strobe per voted data/parity bit.
- `rx_bit`  out  1  voted bit value, valid on and held after `rx_data_signal`.
- `bit_index`  out  4  index of the bit strobed: 0–7 data (LSB first), 8 parity.
- `stop_check`  out  1  one-cycle pulse: stop bit voted high.
- `frame_err`  out  1  one-cycle pulse: stop bit voted low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Two-flop synchroniser on `rx_in`; both flops reset to 1. `rxs` denotes its output.
- Tick generator: `div_cnt` counts 0..DIV-1; `tick` when `div_cnt == DIV-1`. `os_cnt` (4 bits) increments on `tick`, wraps 15→0. Both clear on every entry to START.
- Per bit, samples are captured on ticks with `os_cnt` = 7, 8, 9. The vote is the 2-of-3 majority, decided on the `os_cnt == 9` tick.
- States:
  - IDLE: `rxs == 0` and `enable` → START.
  - START: on the vote, 0 → pulse `rx_start`, set `start_check`. On the vote, 1 → glitch, back to IDLE with no outputs. Tick at `os_cnt == 15` → DATA, `bit_index` = 0.
  - DATA: each vote pulses `rx_data_signal` with `rx_bit`/`bit_index`. The tick at `os_cnt == 15` advances `bit_index`. After the last bit (index 7, or 8 with parity), → STOP.
  - STOP: on the vote, 1 → pulse `stop_check`, clear `start_check`, → IDLE immediately (no wait for end of stop bit). On the vote, 0 → pulse `frame_err`, clear `start_check`, → BREAK.
  - BREAK: wait for `rxs == 1`, then → IDLE. Suppresses false start on a held-low line.
- `enable` low in any state: next cycle IDLE. All pulses 0, `start_check` cleared. Counters are cleared; `rx_bit` and `bit_index` are held.
- Reset values: all outputs 0, state IDLE, counters 0, synchroniser 1.

## Timing
- `rx_in` falling edge → `rxs` low: 2 cycles. IDLE→START: +1 cycle.
- Entering START at cycle S (`div_cnt` = 0, `os_cnt` = 0), the start vote occurs at cycle S + 10·DIV − 1. `rx_start` is registered high on cycle S + 10·DIV.
- Successive `rx_data_signal` strobes are exactly 16·DIV cycles apart. The first strobe is 16·DIV cycles after `rx_start`.
- All pulses last exactly one cycle and never coincide with each other.
- Async `reset` assertion mid-frame: outputs go to reset values immediately, without waiting for a clock edge. After release, the receiver waits in IDLE for a new falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined: DATA covers 9 bits; index 8 is the parity bit, strobed like a data bit.
- Not defined: DATA covers 8 bits and `bit_index` never reaches 8. STOP follows bit 7 directly.

## Test plan
- DIV=4, parity on, frame 0xA5 with even parity 0 and stop 1: `rx_start` at S+40, then 9 strobes 64 cycles apart with bits 1,0,1,0,0,1,0,1,0 and indices 0–8, then `stop_check` pulse; `frame_err` stays 0.
- `rx_in` low for 6 ticks (24 cycles), then high: no `rx_start`, back to IDLE, `busy` drops after the START vote.
- A 1-cycle noise pulse injected on `rx_in` at `os_cnt == 8` of data bit 3 with value 1: majority still yields 1, same strobe timing.
- Stop bit held 0 for 3 bit times: `frame_err` pulses once, state held in BREAK, no `rx_start` until line high then a new falling edge.
- `enable` dropped during bit 4: no further strobes; `start_check` 0 next cycle; the next frame after re-enable is received correctly.
- Async `reset` asserted mid-DATA: all outputs 0 immediately; after release, a full 0x3C frame is received correctly. Repeat with parity off to confirm 8 strobes then `stop_check`.
